// File: rtl/mult_seq_par.sv
// Signed sequential shift-add multiplier with operand parity checking and result parity.
// Magnitudes are multiplied STEP bits per cycle; the sign is applied once at the end.
module mult_seq_par #(
    parameter int WIDTH      = 16,
    parameter int STEP       = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic [WIDTH-1:0]   arg_a,
    input  logic               arg_a_parity,
    input  logic [WIDTH-1:0]   arg_b,
    input  logic               arg_b_parity,
    output logic               ack,
    output logic [2*WIDTH-1:0] result,
    output logic               result_parity,
    output logic               arg_parity_error,
    output logic               result_rdy
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = 2 * WIDTH;

    localparam logic            ODD    = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RW-1:0]    ONE_R = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [RW-1:0]    ZERO_R = {RW{1'b0}};
    localparam logic [CW-1:0]    ONE_C = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0]    LAST_C = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic par_w(input logic [WIDTH-1:0] d);
        return (^d) ^ ODD;
    endfunction

    function automatic logic par_r(input logic [RW-1:0] d);
        return (^d) ^ ODD;
    endfunction

    // Unsigned magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1) without loss.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] d);
        return d[WIDTH-1] ? (~d + ONE_W) : d;
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_mag_q, b_mag_d;
    logic [RW-1:0]     acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              perr_q, perr_d;
    logic              ack_q, ack_d;
    logic [RW-1:0]     result_q, result_d;
    logic              result_parity_q, result_parity_d;
    logic              arg_parity_error_q, arg_parity_error_d;
    logic              result_rdy_q, result_rdy_d;

    logic [RW-1:0]     partial_s;
    logic [RW-1:0]     prod_s;
    logic [RW-1:0]     signed_s;

    // Partial product of the current STEP multiplier bits, and the signed final value.
    always_comb begin
        partial_s = ZERO_R;
        for (int j = 0; j < STEP; j++) begin
            if (b_mag_q[j]) begin
                partial_s = partial_s + (a_sh_q << j);
            end else begin
                partial_s = partial_s;
            end
        end
        prod_s   = acc_q + partial_s;
        signed_s = neg_q ? (~prod_s + ONE_R) : prod_s;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        a_sh_d             = a_sh_q;
        b_mag_d            = b_mag_q;
        acc_d              = acc_q;
        neg_d              = neg_q;
        perr_d             = perr_q;
        ack_d              = 1'b0;
        result_d           = result_q;
        result_parity_d    = result_parity_q;
        arg_parity_error_d = arg_parity_error_q;
        result_rdy_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    ack_d   = 1'b1;
                    a_sh_d  = {{WIDTH{1'b0}}, mag(arg_a)};
                    b_mag_d = mag(arg_b);
                    acc_d   = ZERO_R;
                    cnt_d   = ZERO_C;
                    neg_d   = arg_a[WIDTH-1] ^ arg_b[WIDTH-1];
                    perr_d  = (arg_a_parity != par_w(arg_a)) | (arg_b_parity != par_w(arg_b));
                    state_d = perr_d ? DONE : BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                acc_d   = prod_s;
                a_sh_d  = a_sh_q << STEP;
                b_mag_d = b_mag_q >> STEP;
                cnt_d   = cnt_q + ONE_C;
                if (cnt_q == LAST_C) begin
                    state_d            = DONE;
                    result_rdy_d       = 1'b1;
                    result_d           = signed_s;
                    result_parity_d    = par_r(signed_s);
                    arg_parity_error_d = 1'b0;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                state_d = IDLE;
                // A rejected transaction reports one cycle later than it enters DONE.
                if (perr_q) begin
                    result_rdy_d       = 1'b1;
                    result_d           = ZERO_R;
                    result_parity_d    = par_r(ZERO_R);
                    arg_parity_error_d = 1'b1;
                end else begin
                    result_rdy_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            cnt_q              <= ZERO_C;
            a_sh_q             <= ZERO_R;
            b_mag_q            <= {WIDTH{1'b0}};
            acc_q              <= ZERO_R;
            neg_q              <= 1'b0;
            perr_q             <= 1'b0;
            ack_q              <= 1'b0;
            result_q           <= ZERO_R;
            result_parity_q    <= 1'b0;
            arg_parity_error_q <= 1'b0;
            result_rdy_q       <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            a_sh_q             <= a_sh_d;
            b_mag_q            <= b_mag_d;
            acc_q              <= acc_d;
            neg_q              <= neg_d;
            perr_q             <= perr_d;
            ack_q              <= ack_d;
            result_q           <= result_d;
            result_parity_q    <= result_parity_d;
            arg_parity_error_q <= arg_parity_error_d;
            result_rdy_q       <= result_rdy_d;
        end
    end

    assign ack              = ack_q;
    assign result           = result_q;
    assign result_parity    = result_parity_q;
    assign arg_parity_error = arg_parity_error_q;
    assign result_rdy       = result_rdy_q;

endmodule

// File: tb/tb_mult_seq_par.sv
// Scoreboard bench for mult_seq_par: default 16x16/STEP1/even instance and an 8-bit/STEP4/odd instance.
module tb_mult_seq_par;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0, pa0, pb0, ack0, rp0, pe0, rdy0;
    logic [15:0] a0, b0;
    logic [31:0] res0;
    logic        req1, pa1, pb1, ack1, rp1, pe1, rdy1;
    logic [7:0]  a1, b1;
    logic [15:0] res1;

    mult_seq_par u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0),
        .arg_a(a0), .arg_a_parity(pa0), .arg_b(b0), .arg_b_parity(pb0),
        .ack(ack0), .result(res0), .result_parity(rp0),
        .arg_parity_error(pe0), .result_rdy(rdy0)
    );

    mult_seq_par #(.WIDTH(8), .STEP(4), .PARITY_ODD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1),
        .arg_a(a1), .arg_a_parity(pa1), .arg_b(b1), .arg_b_parity(pb1),
        .ack(ack1), .result(res1), .result_parity(rp1),
        .arg_parity_error(pe1), .result_rdy(rdy1)
    );

    typedef struct {
        logic [31:0] res;
        logic        par;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int push0 = 0, push1 = 0, rdy0_cnt = 0, rdy1_cnt = 0;
    bit idle_before = 1'b1;
    logic [31:0] hold_res0 = 32'h0;
    logic        hold_rp0 = 1'b0, hold_pe0 = 1'b0;
    logic [15:0] hold_res1 = 16'h0;
    logic        hold_rp1 = 1'b0, hold_pe1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: signed product by plain arithmetic, zero on rejected operands.
    function automatic exp_t model(input int inst, input logic [15:0] a, input logic [15:0] b,
                                   input bit err, input int ack_cyc);
        longint sa, sb, p;
        exp_t e;
        if (inst == 0) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'($signed(a[7:0]));
            sb = longint'($signed(b[7:0]));
        end
        p = sa * sb;
        if (err) e.res = 32'h0;
        else if (inst == 0) e.res = p[31:0];
        else e.res = {16'h0, p[15:0]};
        e.par = (^e.res) ^ (inst == 1);
        e.err = err;
        e.cyc = ack_cyc + (err ? 1 : ((inst == 0) ? 16 : 2));
        return e;
    endfunction

    function automatic logic [15:0] rnd_op(input int inst);
        logic [15:0] v;
        case ($urandom_range(0, 5))
            0: v = (inst == 0) ? 16'h8000 : 16'h0080;
            1: v = (inst == 0) ? 16'h7FFF : 16'h007F;
            2: v = 16'h0000;
            3: v = 16'hFFFF;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    task automatic txn(input int inst, input logic [15:0] a, input logic [15:0] b,
                       input bit bad_a, input bit bad_b, input bit keep);
        int t;
        int req_cyc;
        bit got;
        bit err;
        err = bad_a | bad_b;
        if (inst == 0) begin
            a0 = a; b0 = b; pa0 = (^a) ^ bad_a; pb0 = (^b) ^ bad_b; req0 = 1'b1;
        end else begin
            a1 = a[7:0]; b1 = b[7:0];
            pa1 = ~(^a[7:0]) ^ bad_a; pb1 = ~(^b[7:0]) ^ bad_b; req1 = 1'b1;
        end
        req_cyc = cyc;
        t = 0;
        got = 1'b0;
        while (!got && t < 60) begin
            @(negedge clk);
            t++;
            got = (inst == 0) ? ack0 : ack1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout inst=%0d: no ack seen, required ack within 60 cycles", inst);
        end else begin
            if (inst == 0) begin q0.push_back(model(0, a, b, err, cyc)); push0++; end
            else begin q1.push_back(model(1, a, b, err, cyc)); push1++; end
            if (idle_before) begin
                checks++;
                if (cyc != req_cyc + 1) begin
                    errors++;
                    $display("FAIL ack_latency inst=%0d: ack in cycle %0d, required %0d",
                             inst, cyc, req_cyc + 1);
                end
            end
        end
        if (!keep) begin
            if (inst == 0) begin req0 = 1'b0; a0 = 16'($urandom); b0 = 16'($urandom); end
            else begin req1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom); end
            t = 0;
            while (((inst == 0) ? (rdy0_cnt != push0) : (rdy1_cnt != push1)) && t < 60) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (t >= 60) begin
                errors++;
                $display("FAIL drain_timeout inst=%0d: results outstanding after 60 cycles", inst);
            end
            @(negedge clk);
        end
        idle_before = !keep;
    endtask

    // Monitor for the 16-bit instance.
    initial begin
        exp_t e;
        logic prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ack0) begin
                    checks++;
                    if (prev_ack) begin
                        errors++;
                        $display("FAIL ack_pulse inst=0: ack high 2 cycles, required 1-cycle pulse");
                    end
                end
                prev_ack = ack0;
                if (rdy0) begin
                    checks++;
                    if (q0.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rdy inst=0: result_rdy with no pending request");
                    end else begin
                        e = q0.pop_front();
                        checks += 4;
                        if (res0 !== e.res) begin errors++;
                            $display("FAIL result inst=0: got %h required %h", res0, e.res); end
                        if (rp0 !== e.par) begin errors++;
                            $display("FAIL result_parity inst=0: got %b required %b", rp0, e.par); end
                        if (pe0 !== e.err) begin errors++;
                            $display("FAIL arg_parity_error inst=0: got %b required %b", pe0, e.err); end
                        if (cyc != e.cyc) begin errors++;
                            $display("FAIL rdy_latency inst=0: cycle %0d required %0d", cyc, e.cyc); end
                    end
                    hold_res0 = res0; hold_rp0 = rp0; hold_pe0 = pe0;
                    rdy0_cnt++;
                end else begin
                    checks++;
                    if (res0 !== hold_res0 || rp0 !== hold_rp0 || pe0 !== hold_pe0) begin
                        errors++;
                        $display("FAIL hold inst=0: got %h/%b/%b required %h/%b/%b",
                                 res0, rp0, pe0, hold_res0, hold_rp0, hold_pe0);
                    end
                end
            end else begin
                prev_ack = 1'b0;
            end
        end
    end

    // Monitor for the 8-bit instance.
    initial begin
        exp_t e;
        logic prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ack1) begin
                    checks++;
                    if (prev_ack) begin
                        errors++;
                        $display("FAIL ack_pulse inst=1: ack high 2 cycles, required 1-cycle pulse");
                    end
                end
                prev_ack = ack1;
                if (rdy1) begin
                    checks++;
                    if (q1.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rdy inst=1: result_rdy with no pending request");
                    end else begin
                        e = q1.pop_front();
                        checks += 4;
                        if (res1 !== e.res[15:0]) begin errors++;
                            $display("FAIL result inst=1: got %h required %h", res1, e.res[15:0]); end
                        if (rp1 !== e.par) begin errors++;
                            $display("FAIL result_parity inst=1: got %b required %b", rp1, e.par); end
                        if (pe1 !== e.err) begin errors++;
                            $display("FAIL arg_parity_error inst=1: got %b required %b", pe1, e.err); end
                        if (cyc != e.cyc) begin errors++;
                            $display("FAIL rdy_latency inst=1: cycle %0d required %0d", cyc, e.cyc); end
                    end
                    hold_res1 = res1; hold_rp1 = rp1; hold_pe1 = pe1;
                    rdy1_cnt++;
                end else begin
                    checks++;
                    if (res1 !== hold_res1 || rp1 !== hold_rp1 || pe1 !== hold_pe1) begin
                        errors++;
                        $display("FAIL hold inst=1: got %h/%b/%b required %h/%b/%b",
                                 res1, rp1, pe1, hold_res1, hold_rp1, hold_pe1);
                    end
                end
            end else begin
                prev_ack = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bit keep;
        req0 = 1'b0; a0 = 16'h0; b0 = 16'h0; pa0 = 1'b0; pb0 = 1'b0;
        req1 = 1'b0; a1 = 8'h0;  b1 = 8'h0;  pa1 = 1'b0; pb1 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ack0, res0, rp0, pe0, rdy0, ack1, res1, rp1, pe1, rdy1} !== 56'h0) begin
            errors++;
            $display("FAIL reset_state: outputs %h, required all zero",
                     {ack0, res0, rp0, pe0, rdy0, ack1, res1, rp1, pe1, rdy1});
        end
        rst_n = 1'b1;
        @(negedge clk);

        txn(0, 16'd3, 16'hFFFB, 1'b0, 1'b0, 1'b0);
        txn(0, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
        txn(0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b0);
        txn(0, 16'd7, 16'd2, 1'b1, 1'b0, 1'b0);
        txn(0, 16'd5, 16'd9, 1'b1, 1'b1, 1'b0);
        txn(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);

        // Abort a transaction in the middle of BUSY.
        a0 = 16'd1234; b0 = 16'hFFB3; pa0 = ^a0; pb0 = ^b0; req0 = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!ack0 && t < 60);
        checks++;
        if (!ack0) begin errors++; $display("FAIL reset_txn_ack: no ack, required ack"); end
        req0 = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ack0, res0, rp0, pe0, rdy0, ack1, res1, rp1, pe1, rdy1} !== 56'h0) begin
            errors++;
            $display("FAIL reset_abort: outputs %h, required all zero",
                     {ack0, res0, rp0, pe0, rdy0, ack1, res1, rp1, pe1, rdy1});
        end
        hold_res0 = 32'h0; hold_rp0 = 1'b0; hold_pe0 = 1'b0;
        hold_res1 = 16'h0; hold_rp1 = 1'b0; hold_pe1 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (25) @(negedge clk);
        idle_before = 1'b1;
        txn(0, 16'hFFFF, 16'h8000, 1'b0, 1'b0, 1'b0);

        // req held high: operands change during BUSY and become the next transaction.
        for (int i = 0; i < 6; i++) begin
            txn(0, rnd_op(0), rnd_op(0), ($urandom_range(0, 5) == 0), 1'b0, (i != 5));
        end
        for (int i = 0; i < 40; i++) begin
            keep = (i != 39) && ($urandom_range(0, 1) == 1);
            txn(0, rnd_op(0), rnd_op(0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 5) == 0), keep);
        end

        txn(1, 16'h0080, 16'h007F, 1'b0, 1'b0, 1'b0);
        txn(1, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0);
        txn(1, 16'h0080, 16'h0080, 1'b0, 1'b0, 1'b0);
        txn(1, 16'd7, 16'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            keep = (i != 29) && ($urandom_range(0, 1) == 1);
            txn(1, rnd_op(1), rnd_op(1), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 5) == 0), keep);
        end

        repeat (5) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d/%0d results still expected, required 0/0",
                     q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
